// File: rtl/pagerank_pkg.sv
// Shared constants and types for the PageRank rank sorter: default sizes,
// controller states and the {index, value} entry layout.
package pagerank_pkg;

    localparam int PR_N     = 4;
    localparam int PR_WIDTH = 16;
    localparam int PR_IDXW  = $clog2(PR_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        EMIT = 2'd2
    } pr_state_t;

    // Default-size entry; parameterised instances use the same {idx, val} packing.
    typedef struct packed {
        logic [PR_IDXW-1:0]  idx;
        logic [PR_WIDTH-1:0] val;
    } pr_entry_t;

endpackage

// File: rtl/pr_cmp_swap.sv
// Combinational compare-exchange of two packed {idx, val} entries: higher value
// first, equal values ordered by lower index so the network result is unique.
module pr_cmp_swap
    import pagerank_pkg::*;
#(
    parameter int IDXW  = PR_IDXW,
    parameter int WIDTH = PR_WIDTH
) (
    input  logic [IDXW+WIDTH-1:0] a_i,
    input  logic [IDXW+WIDTH-1:0] b_i,
    output logic [IDXW+WIDTH-1:0] first_o,
    output logic [IDXW+WIDTH-1:0] second_o
);

    logic [IDXW-1:0]  a_idx, b_idx;
    logic [WIDTH-1:0] a_val, b_val;
    logic             a_first;

    assign {a_idx, a_val} = a_i;
    assign {b_idx, b_val} = b_i;

    assign a_first  = (a_val > b_val) || ((a_val == b_val) && (a_idx < b_idx));
    assign first_o  = a_first ? a_i : b_i;
    assign second_o = a_first ? b_i : a_i;

endmodule

// File: rtl/pagerank_rank_sorter.sv
// Captures a rank vector, sorts it descending with N passes of odd-even
// transposition, then streams {index, value} beats under valid/ready.
module pagerank_rank_sorter
    import pagerank_pkg::*;
#(
    parameter int N     = PR_N,
    parameter int WIDTH = PR_WIDTH,
    parameter int IDXW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] node_vals,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDXW-1:0]    out_idx,
    output logic [WIDTH-1:0]   out_val,
    output logic               out_last,
    output logic               busy
);

    localparam int EW = IDXW + WIDTH;
    localparam int PW = $clog2(N + 1);
    localparam int NP = N / 2;

    pr_state_t        state_q, state_d;
    logic [IDXW-1:0]  pass_q, pass_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [EW-1:0]    ent_q [N];
    logic [EW-1:0]    ent_d [N];
    logic [EW-1:0]    pass_ent [N];
    logic [EW-1:0]    cmp_a [NP];
    logic [EW-1:0]    cmp_b [NP];
    logic [EW-1:0]    cmp_f [NP];
    logic [EW-1:0]    cmp_s [NP];
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [IDXW-1:0]  out_idx_q, out_idx_d;
    logic [WIDTH-1:0] out_val_q, out_val_d;
    logic             odd_pass;

    assign odd_pass = pass_q[0];

    // Odd passes leave entries 0 and N-1 alone; the last comparator's result is unused then.
    for (genvar k = 0; k < NP; k++) begin : g_cmp
        localparam int EA = 2 * k;
        localparam int EB = 2 * k + 1;
        localparam int OA = 2 * k + 1;
        localparam int OB = (2 * k + 2) % N;

        assign cmp_a[k] = odd_pass ? ent_q[OA] : ent_q[EA];
        assign cmp_b[k] = odd_pass ? ent_q[OB] : ent_q[EB];

        pr_cmp_swap #(
            .IDXW (IDXW),
            .WIDTH(WIDTH)
        ) u_cmp (
            .a_i     (cmp_a[k]),
            .b_i     (cmp_b[k]),
            .first_o (cmp_f[k]),
            .second_o(cmp_s[k])
        );
    end

    always_comb begin
        for (int i = 0; i < N; i++) pass_ent[i] = ent_q[i];
        for (int k = 0; k < NP; k++) begin
            if (!odd_pass) begin
                pass_ent[2*k]   = cmp_f[k];
                pass_ent[2*k+1] = cmp_s[k];
            end else if (k < NP - 1) begin
                pass_ent[2*k+1]         = cmp_f[k];
                pass_ent[(2*k+2) % N]   = cmp_s[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        out_val_d   = out_val_q;
        for (int i = 0; i < N; i++) ent_d[i] = ent_q[i];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int k = 0; k < N; k++) ent_d[k] = {IDXW'(k), node_vals[k*WIDTH +: WIDTH]};
                    state_d = SORT;
                    pass_d  = '0;
                end
            end
            SORT: begin
                for (int i = 0; i < N; i++) ent_d[i] = pass_ent[i];
                pass_d = pass_q + 1'b1;
                if (pass_q == IDXW'(N - 1)) begin
                    state_d = EMIT;
                    pass_d  = '0;
                    ptr_d   = '0;
                end
            end
            EMIT: begin
                // ptr_q names the next entry to load into the output register.
                if (!out_valid_q || out_ready) begin
                    if (ptr_q < PW'(N)) begin
                        out_valid_d            = 1'b1;
                        {out_idx_d, out_val_d} = ent_q[ptr_q[IDXW-1:0]];
                        out_last_d             = (ptr_q == PW'(N - 1));
                        ptr_d                  = ptr_q + 1'b1;
                    end else begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        ptr_d       = '0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pass_q      <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= '0;
            out_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
            out_val_q   <= out_val_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_idx   = out_idx_q;
    assign out_val   = out_val_q;

endmodule

// File: tb/tb_pagerank_rank_sorter.sv
// Directed bench for pagerank_rank_sorter: a reference ordering is queued per
// vector and each output beat is checked against it.
module tb_pagerank_rank_sorter;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int IDXW = 2;
    localparam int EW   = IDXW + W;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   node_vals;
    logic             out_valid;
    logic             out_ready;
    logic [IDXW-1:0]  out_idx;
    logic [W-1:0]     out_val;
    logic             out_last;
    logic             busy;

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;
    logic [EW-1:0] sb[$];

    pagerank_rank_sorter #(.N(N), .WIDTH(W), .IDXW(IDXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .node_vals(node_vals),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_val  (out_val),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input logic [W-1:0] v0, input logic [W-1:0] v1,
                                              input logic [W-1:0] v2, input logic [W-1:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    // Reference order: repeatedly pick the largest remaining value, lowest index on ties.
    task automatic push_expected(input logic [N*W-1:0] vals);
        logic [W-1:0] v [N];
        bit           used [N];
        int           best;
        for (int i = 0; i < N; i++) begin
            v[i]    = vals[i*W +: W];
            used[i] = 1'b0;
        end
        for (int r = 0; r < N; r++) begin
            best = -1;
            for (int i = 0; i < N; i++) begin
                if (!used[i] && (best < 0 || v[i] > v[best])) best = i;
            end
            used[best] = 1'b1;
            sb.push_back({IDXW'(best), v[best]});
        end
    endtask

    task automatic run_vector(input logic [N*W-1:0] vals, input int stall_beat,
                              input int stall_len, input bit hold_valid);
        int            cnt;
        int            beat;
        int            rem;
        int            acc0;
        logic [EW-1:0] exp;
        cnt = 0;
        while (!in_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("in_ready_wait", in_ready, 1);
        push_expected(vals);
        acc0      = acc_cnt;
        in_valid  = 1'b1;
        node_vals = vals;
        @(negedge clk);
        if (!hold_valid) in_valid = 1'b0;
        chk("accept_busy", busy, 1);
        chk("sort_in_ready", in_ready, 0);
        cnt = 0;
        while (!out_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_valid_latency", cnt, N + 1);
        beat = 0;
        rem  = stall_len;
        cnt  = 0;
        while (beat < N && cnt < 200) begin
            cnt++;
            exp = (sb.size() > 0) ? sb[0] : '0;
            chk("emit_valid", out_valid, 1);
            chk("emit_in_ready", in_ready, 0);
            chk("out_idx", out_idx, exp[EW-1:W]);
            chk("out_val", out_val, exp[W-1:0]);
            chk("out_last", out_last, (beat == N - 1));
            if (beat == stall_beat && rem > 0) begin
                out_ready = 1'b0;
                rem--;
            end else begin
                out_ready = 1'b1;
                if (sb.size() > 0) void'(sb.pop_front());
                beat++;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("accepts_per_visit", acc_cnt - acc0, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        node_vals = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_val", out_val, 0);
        reset = 1'b0;
        @(negedge clk);

        // Basic sort, ties, reverse order, full-width extremes.
        run_vector(pack4(16'h2000, 16'h6000, 16'h1000, 16'h4000), -1, 0, 1'b0);
        run_vector(pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), -1, 0, 1'b0);
        run_vector(pack4(16'h1000, 16'h2000, 16'h3000, 16'h4000), -1, 0, 1'b0);
        run_vector(pack4(16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF), -1, 0, 1'b0);

        // Backpressure at the second beat.
        run_vector(pack4(16'h2000, 16'h6000, 16'h1000, 16'h4000), 1, 3, 1'b0);

        // Reset in SORT pass 2 discards the vector.
        in_valid  = 1'b1;
        node_vals = pack4(16'h9000, 16'h0100, 16'hA000, 16'h0200);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy_clr", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_idx", out_idx, 0);
        chk("abort_out_val", out_val, 0);
        chk("abort_out_last", out_last, 0);
        run_vector(pack4(16'h0001, 16'h0003, 16'h0002, 16'h0000), -1, 0, 1'b0);

        // Reset wins over a simultaneous accept.
        reset     = 1'b1;
        in_valid  = 1'b1;
        node_vals = pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_accept_busy", busy, 0);
        chk("rst_accept_in_ready", in_ready, 1);
        @(negedge clk);
        chk("rst_accept_idle", busy, 0);

        // in_valid held high across two back-to-back vectors.
        run_vector(pack4(16'h0500, 16'h0700, 16'h0300, 16'h0600), -1, 0, 1'b1);
        run_vector(pack4(16'hC000, 16'h0010, 16'hC000, 16'h0020), 2, 2, 1'b1);
        in_valid = 1'b0;

        // Random values from a small range to force ties.
        for (int r = 0; r < 3; r++) begin
            run_vector(pack4(W'($urandom_range(0, 3)) << 12, W'($urandom_range(0, 3)) << 12,
                             W'($urandom_range(0, 3)) << 12, W'($urandom_range(0, 3)) << 12),
                       r, 1, 1'b0);
        end

        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pagerank_rank_sorter.md
PAGERANK_RANK_SORTER -- requirements
Module: pagerank_rank_sorter

Interface
REQ-001 Parameter N, default 4, meaning number of graph nodes; the block SHALL support even N >= 2.
REQ-002 Parameter WIDTH, default 16, meaning node value width (unsigned fixed point, 2^-16 LSB).
REQ-003 Parameter IDXW, default $clog2(N), meaning node index width.
REQ-004 clk  input  1  meaning the single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  meaning the reset, which SHALL be synchronous and active-high.
REQ-006 in_valid  input  1  meaning that a new rank vector is present on node_vals.
REQ-007 in_ready  output  1  meaning the block accepts a vector; it SHALL be high only in IDLE.
REQ-008 node_vals  input  N*WIDTH  meaning the rank vector; node k SHALL occupy bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  meaning that out_idx, out_val and out_last are valid.
REQ-010 out_ready  input  1  meaning the downstream consumer accepts the current output beat.
REQ-011 out_idx  output  IDXW  meaning the node index of the current beat.
REQ-012 out_val  output  WIDTH  meaning the node value of the current beat.
REQ-013 out_last  output  1  meaning the final (lowest-ranked) beat of a vector.
REQ-014 busy  output  1  meaning the block is in SORT or EMIT.

Function
REQ-015 The block SHALL implement the states IDLE, SORT and EMIT.
REQ-016 A vector SHALL be accepted on an edge where in_valid and in_ready are both high; this is the accept edge.
  - On the accept edge the block SHALL capture N {index, value} pairs (index k paired with node_vals slice k).
  - The block SHALL then move to SORT with the pass counter set to 0.
REQ-017 SORT SHALL run exactly N cycles of odd-even transposition, one pass per cycle.
  - Pass p even: compare-exchange pairs (0,1), (2,3), ...
  - Pass p odd: compare-exchange pairs (1,2), (3,4), ...
REQ-018 Compare-exchange order SHALL be descending by value.
  - Tie rule: the lower index SHALL come first.
  - Result: the sort is stable and deterministic.
REQ-019 After pass N-1 the block SHALL enter EMIT with the read pointer at 0.
  - out_valid SHALL first be high N+1 cycles after the accept edge.
REQ-020 In EMIT, out_valid SHALL stay high and out_idx/out_val SHALL show sorted entry[ptr].
  - A beat SHALL complete on each cycle with out_valid and out_ready both high; the pointer then increments.
REQ-021 While out_ready is low, out_idx, out_val and out_last SHALL hold stable.
REQ-022 out_last SHALL be high only when ptr == N-1.
  - Completion of the last beat SHALL return the block to IDLE, with in_ready high on the next cycle.
REQ-023 in_valid SHALL be ignored in SORT and EMIT; vectors SHALL NOT be queued.
REQ-024 Value comparison SHALL be unsigned over the full WIDTH; no arithmetic SHALL modify values.

Reset
REQ-025 When reset is high at an edge, the block SHALL enter IDLE, in any state, mid-SORT or mid-EMIT included.
  - The pass counter and pointer SHALL clear to 0.
  - Any partial sort or emission SHALL be discarded.
REQ-026 Output values in the cycle after reset:
  - out_valid=0, out_last=0, busy=0, in_ready=1.
  - out_idx=0, out_val=0.
  - The stored pairs SHALL be don't-care.
REQ-027 reset SHALL take priority over a simultaneous accept; no vector SHALL be captured on that edge.

Structure
REQ-028 The package pagerank_pkg SHALL hold the shared constants and typedefs:
  - WIDTH and N defaults.
  - The state enum {IDLE, SORT, EMIT}.
  - The {index, value} entry typedef.
REQ-029 One sub-module, pr_cmp_swap, SHALL implement a purely combinational compare-exchange of two entries under REQ-018.
  - The top SHALL instantiate N/2 copies and route pairs according to pass parity.
REQ-030 The datapath SHALL use no multipliers or memories; the storage SHALL be N entry registers.

Verification
REQ-031 Basic sort: node_vals {0x2000,0x6000,0x1000,0x4000} (node 0..3), out_ready=1.
  - Beats (1,0x6000), (3,0x4000), (0,0x2000), (2,0x1000).
  - out_last on the 4th beat; first out_valid 5 cycles after the accept edge.
REQ-032 Ties: all four values 0x4000 -> idx 0,1,2,3 in order.
  - Reverse-sorted input {0x1000,0x2000,0x3000,0x4000} -> idx 3,2,1,0.
REQ-033 Backpressure: out_ready low for 3 cycles at the 2nd beat.
  - out_idx/out_val held stable and no beat lost or duplicated.
  - Sequence identical to REQ-031.
REQ-034 Reset at SORT pass 2 -> IDLE next cycle.
  - The next vector {0x0001,0x0003,0x0002,0x0000} -> idx 1,2,0,3.
  - No residue from the aborted vector.
REQ-035 in_valid held high throughout -> exactly one vector accepted per IDLE visit.
  - in_ready low during SORT/EMIT.
  - Re-accept on the cycle after the out_last beat completes.
